// File: rtl/font_pkg.sv
// Font ROM types and widths shared by the arbiter and the draw_* text stages.
package font_pkg;

    localparam int unsigned FONT_ADDR_W = 11;
    localparam int unsigned FONT_DATA_W = 8;
    localparam int unsigned CHAR_LINE_W = 4;

    typedef struct packed {
        logic                   req;
        logic [FONT_ADDR_W-1:0] addr;
    } font_req_t;

    // ROM address of one pixel line of a character glyph.
    function automatic logic [FONT_ADDR_W-1:0] font_addr(input logic [6:0] char_code,
                                                         input logic [CHAR_LINE_W-1:0] char_line);
        return {char_code, char_line};
    endfunction

endpackage

// File: rtl/rr_arbiter_core.sv
// Combinational round-robin find-first: the first set req bit at or above ptr, modulo N_REQ.
module rr_arbiter_core
    import font_pkg::*;
#(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned PTR_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [PTR_W-1:0] ptr_i,
    output logic [N_REQ-1:0] gnt_o
);

    logic [PTR_W:0]   sum;
    logic [PTR_W-1:0] idx;
    logic             found;

    // Walk the requesters in rotated order; the first hit wins.
    always_comb begin
        gnt_o = '0;
        found = 1'b0;
        sum   = '0;
        idx   = '0;
        for (int k = 0; k < int'(N_REQ); k++) begin
            sum = {1'b0, ptr_i} + (PTR_W + 1)'(k);
            // Explicit wrap so non-power-of-2 N_REQ never indexes past the top requester.
            if (sum >= (PTR_W + 1)'(N_REQ)) begin
                sum = sum - (PTR_W + 1)'(N_REQ);
            end
            idx = sum[PTR_W-1:0];
            if (!found && req_i[idx]) begin
                gnt_o[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/font_rom_arbiter.sv
// Shares one synchronous font ROM port between N_REQ text stages, one lookup per clock,
// returning each ROM line to its requester tagged by a one-hot valid.
module font_rom_arbiter
    import font_pkg::*;
#(
    parameter int unsigned N_REQ   = 4,
    parameter int unsigned ADDR_W  = FONT_ADDR_W,
    parameter int unsigned DATA_W  = FONT_DATA_W,
    parameter int unsigned ROM_LAT = 1
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic [N_REQ-1:0]        req_i,
    input  logic [N_REQ*ADDR_W-1:0] req_addr_i,
    output logic [N_REQ-1:0]        gnt_o,
    output logic                    rom_en_o,
    output logic [ADDR_W-1:0]       rom_addr_o,
    input  logic [DATA_W-1:0]       rom_data_i,
    output logic [N_REQ-1:0]        rsp_valid_o,
    output logic [DATA_W-1:0]       rsp_data_o
);

    localparam int unsigned PTR_W = $clog2(N_REQ);

    logic [PTR_W-1:0]  ptr_q, ptr_d;
    logic [N_REQ-1:0]  core_gnt;
    logic [N_REQ-1:0]  xfer_vec;
    logic              xfer;
    logic [PTR_W-1:0]  win_idx;
    logic [ADDR_W-1:0] win_addr;

    logic              rom_en_q, rom_en_d;
    logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
    logic [N_REQ-1:0]  tag_q [ROM_LAT+1];
    logic [N_REQ-1:0]  rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_data_q, rsp_data_d;

    rr_arbiter_core #(
        .N_REQ (N_REQ),
        .PTR_W (PTR_W)
    ) u_core (
        .req_i (req_i),
        .ptr_i (ptr_q),
        .gnt_o (core_gnt)
    );

    // Grant is suppressed while reset is held so no stage sees a phantom handshake.
    assign gnt_o = rst_ni ? core_gnt : '0;

    // Decode the winner and compute the next issue, pointer and response values.
    always_comb begin
        xfer_vec = req_i & gnt_o;
        xfer     = |xfer_vec;
        win_idx  = '0;
        win_addr = '0;
        for (int i = 0; i < int'(N_REQ); i++) begin
            if (xfer_vec[i]) begin
                win_idx  = PTR_W'(i);
                win_addr = req_addr_i[i*ADDR_W +: ADDR_W];
            end
        end

        ptr_d      = ptr_q;
        rom_en_d   = xfer;
        rom_addr_d = rom_addr_q;
        if (xfer) begin
            ptr_d      = (win_idx == PTR_W'(N_REQ - 1)) ? '0 : win_idx + PTR_W'(1);
            rom_addr_d = win_addr;
        end

        rsp_valid_d = tag_q[ROM_LAT];
        rsp_data_d  = rsp_data_q;
        if (|tag_q[ROM_LAT]) begin
            rsp_data_d = rom_data_i;
        end
    end

    // Pointer, ROM issue, tag pipe and response registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q       <= '0;
            rom_en_q    <= 1'b0;
            rom_addr_q  <= '0;
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
            for (int s = 0; s <= int'(ROM_LAT); s++) begin
                tag_q[s] <= '0;
            end
        end else begin
            ptr_q       <= ptr_d;
            rom_en_q    <= rom_en_d;
            rom_addr_q  <= rom_addr_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            tag_q[0]    <= xfer_vec;
            for (int s = 1; s <= int'(ROM_LAT); s++) begin
                tag_q[s] <= tag_q[s-1];
            end
        end
    end

    assign rom_en_o    = rom_en_q;
    assign rom_addr_o  = rom_addr_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_data_o  = rsp_data_q;

    // Grant must be one-hot (or idle) and only ever point at an active request.
    a_gnt_legal : assert property (@(posedge clk_i) disable iff (!rst_ni)
        $onehot0(gnt_o) && ((gnt_o & ~req_i) == '0));

endmodule
